avalon_mm_debug_master: RTL
===========================

Name: avalon_mm_debug_master

Overview:
- Avalon-MM master that drives the debug-mode Avalon slave register file: control reg0, instruction address reg1, external address reg2, data.
- Accepts single-beat commands from a host-side source (JTAG/UART bridge or testbench) over a valid/ready handshake.
- Runs one Avalon read or write per command, honouring waitrequest and a fixed read latency.
- Returns a response (read data plus error flag) over a second valid/ready handshake.

Parameters:
- ADDR_W, 3: Avalon word-address width.
- DATA_W, 32: data width.
- READ_LATENCY, 1: fixed cycles from read acceptance to valid readdata. Legal range 0..3.
- TIMEOUT, 255: maximum cycles waitrequest may stay asserted before the transaction is aborted. Legal range 1..65535.

Ports:
- CLK  in  1  clock. One clock domain; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data. 0 for writes and for errors.
- rsp_error  out  1  transaction timed out.
- chipselect  out  1  Avalon chipselect.
- address  out  ADDR_W  Avalon address.
- write  out  1  Avalon write strobe.
- writedata  out  DATA_W  Avalon write data.
- read  out  1  Avalon read strobe.
- readdata  in  DATA_W  Avalon read data.
- waitrequest  in  1  slave stall. Tie 0 for slaves without it.

Behaviour:
- Reset values: while RST is high, every output is 0 and the state is IDLE. cmd_ready = (state==IDLE) && !RST.
- States: IDLE, BUS, RLAT, RESP.
- IDLE:
  - cmd_ready=1.
  - On a handshake edge (cmd_valid && cmd_ready): latch cmd_addr into address and cmd_wdata into writedata; set chipselect=1; set write=cmd_write, read=!cmd_write; clear the wait counter; go to BUS.
  - A command that is not a write still latches writedata; it is don't-care on the bus.
- BUS:
  - chipselect, read/write, address and writedata are held stable while waitrequest=1.
  - Edge with waitrequest=0: the transfer is accepted and chipselect, read and write drop to 0.
    - Write: go to RESP with rsp_valid=1, rsp_rdata=0, rsp_error=0.
    - Read with READ_LATENCY=0: capture readdata on the same edge and go to RESP.
    - Read with READ_LATENCY>0: load the latency counter with READ_LATENCY-1 and go to RLAT.
  - Edge with waitrequest=1: increment the wait counter. When it reaches TIMEOUT:
    - drop the strobes;
    - go to RESP with rsp_error=1 and rsp_rdata=0.
  - Example: a write stalled for exactly TIMEOUT cycles aborts; it does not complete on cycle TIMEOUT+1.
- RLAT:
  - Decrement the latency counter each edge.
  - On the edge where it is 0, capture readdata into rsp_rdata, set rsp_valid=1 and go to RESP.
  - With READ_LATENCY=1, readdata is sampled on the edge after acceptance.
- RESP:
  - rsp_valid and the response fields are held until an edge with rsp_ready=1.
  - On that edge: rsp_valid=0, go to IDLE. rsp_rdata and rsp_error keep their last values.
  - cmd_ready=0 throughout RESP; no command overlap.
- Latency with no stalls and rsp_ready=1:
  - write: accept edge N, bus cycle N..N+1, rsp_valid high after N+1, cmd_ready high after N+2.
  - read with READ_LATENCY=1: one extra cycle over the write.
- A cmd_valid held through RESP is taken on the first IDLE edge.
- Counters:
  - wait counter: 16 bits, saturating; it never wraps.
  - latency counter: 2 bits.
- Reset mid-transaction: strobes and rsp_valid drop asynchronously and the in-flight command is discarded. No response is produced.
- Read and write are never asserted together. chipselect=1 exactly when read|write.

Decomposition:
- Package debug_pkg holds:
  - the state enum {IDLE, BUS, RLAT, RESP};
  - register address constants REG_CTRL=0, REG_IADDR=1, REG_EADDR=2, REG_DATA=3;
  - op encodings OP_READ=0, OP_WRITE=1.
  - The debug-mode slave side imports the same package.
- No sub-module. Counters and the FSM live in one module, one always_ff block plus one always_comb block.

Test Plan:
- Write: cmd write addr 3 data 0xDEADBEEF, waitrequest=0 → write/chipselect high exactly 1 cycle with address=3 and writedata=0xDEADBEEF; rsp_valid 1 cycle later; rsp_error=0; rsp_rdata=0.
- Read: cmd read addr 1, READ_LATENCY=1, readdata=0x12345678 on the cycle after acceptance → rsp_rdata=0x12345678, rsp_error=0.
- Stall: waitrequest=1 for 3 cycles during a write to addr 2 → strobes and data stable for 4 cycles, then exactly one response.
- Timeout: TIMEOUT=8, waitrequest stuck at 1 on a read → strobes drop after 8 cycles; rsp_valid=1, rsp_error=1, rsp_rdata=0.
- Backpressure: rsp_ready low for 5 cycles with a second cmd_valid pending → rsp held constant and cmd_ready=0; the second command is accepted on the edge after rsp_ready rises.
- Reset mid-read: assert RST while in RLAT → all outputs 0 immediately, without waiting for a clock edge; after release cmd_ready=1 and no stale rsp_valid appears.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug-mode Avalon master and slave register file.
// Holds the master FSM state type, slave register map and command op codes.
package debug_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RLAT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int REG_CTRL  = 0;
  localparam int REG_IADDR = 1;
  localparam int REG_EADDR = 2;
  localparam int REG_DATA  = 3;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/avalon_mm_debug_master.sv
// Avalon-MM master for the debug register file: takes one host command,
// runs a single read or write honouring waitrequest and a fixed read
// latency, then returns rdata/error on a response handshake.
// Ports: CLK/RST (async, active-high); cmd_* command channel in;
// rsp_* response channel out; chipselect/address/write/writedata/read
// out and readdata/waitrequest in on the Avalon side.
module avalon_mm_debug_master
  import debug_pkg::*;
#(
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              chipselect,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              read,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest
);

  localparam logic [1:0] LAT_INIT =
    2'(READ_LATENCY == 0 ? 0 : READ_LATENCY - 1);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t            state, state_n;
  logic              op_q, op_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              err_q, err_n;
  logic [15:0]       wait_q, wait_n;
  logic [15:0]       wait_inc;
  logic [1:0]        lat_q, lat_n;
  logic              busy;

  // Saturating increment so a huge TIMEOUT can never wrap the count.
  assign wait_inc = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      lat_q   <= '0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
      wait_q  <= wait_n;
      lat_q   <= lat_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    err_n   = err_q;
    wait_n  = wait_q;
    lat_n   = lat_q;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_n  = cmd_addr;
          wdata_n = cmd_wdata;
          op_n    = cmd_write ? OP_WRITE : OP_READ;
          wait_n  = '0;
          state_n = BUS;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          if (op_q == OP_WRITE) begin
            rdata_n = '0;
            err_n   = 1'b0;
            state_n = RESP;
          end else if (READ_LATENCY == 0) begin
            rdata_n = readdata;
            err_n   = 1'b0;
            state_n = RESP;
          end else begin
            lat_n   = LAT_INIT;
            state_n = RLAT;
          end
        end else begin
          wait_n = wait_inc;
          // Abort on the edge the count reaches TIMEOUT, not one later.
          if (wait_inc >= TMO) begin
            rdata_n = '0;
            err_n   = 1'b1;
            state_n = RESP;
          end
        end
      end
      RLAT: begin
        if (lat_q == 2'd0) begin
          rdata_n = readdata;
          err_n   = 1'b0;
          state_n = RESP;
        end else begin
          lat_n = lat_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Strobes derive from state so reset clears them without a clock edge.
  assign busy       = (state == BUS);
  assign chipselect = busy;
  assign write      = busy && (op_q == OP_WRITE);
  assign read       = busy && (op_q == OP_READ);
  assign address    = addr_q;
  assign writedata  = wdata_q;
  assign rsp_valid  = (state == RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_error  = err_q;
  assign cmd_ready  = (state == IDLE) && !RST;

endmodule
